// File: rtl/sip_operand_slicer_pkg.sv
// Shared types and helpers for the precision-scalable operand slicer.
package sip_operand_slicer_pkg;

    localparam int unsigned BITS_SHIFT     = 4;
    localparam int unsigned BITS_SLICE_IDX = 2;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Partial-sum weight of slice pair (ia, iw): each slice step is BITS_PARALLEL=2 bits.
    function automatic logic [BITS_SHIFT-1:0] shift_amt(
        input logic [BITS_SLICE_IDX-1:0] ia,
        input logic [BITS_SLICE_IDX-1:0] iw
    );
        logic [BITS_SHIFT-1:0] sum;
        sum = BITS_SHIFT'(ia) + BITS_SHIFT'(iw);
        return sum << 1;
    endfunction

endpackage

// File: rtl/sip_operand_slicer_slice_sel.sv
// Per-element slice mux: picks one BitsParallel-wide slice of an operand by index.
module sip_operand_slicer_slice_sel
    import sip_operand_slicer_pkg::*;
#(
    parameter int unsigned BitsMax      = 8,
    parameter int unsigned BitsParallel = 2
) (
    input  logic [BitsMax-1:0]        operand_i,
    input  logic [BITS_SLICE_IDX-1:0] idx_i,
    output logic [BitsParallel-1:0]   slice_o
);

    localparam int unsigned NumSlices = BitsMax / BitsParallel;

    always_comb begin
        slice_o = '0;
        for (int unsigned s = 0; s < NumSlices; s++) begin
            if (idx_i == BITS_SLICE_IDX'(s)) begin
                slice_o = operand_i[s*BitsParallel +: BitsParallel];
            end
        end
    end

endmodule

// File: rtl/sip_operand_slicer.sv
// Operand sequencer for the 2-bit-sliced dot-product lane: captures one vector and
// emits every (activation-slice, weight-slice) pair as a handshaked beat.
module sip_operand_slicer
    import sip_operand_slicer_pkg::*;
#(
    parameter int unsigned N_DOT         = 32,
    parameter int unsigned BITS_PARALLEL = 2,
    parameter int unsigned BITS_MAX      = 8
) (
    input  logic                            i_CLK,
    input  logic                            i_RST,
    input  logic                            i_Valid,
    output logic                            o_Ready,
    input  logic [N_DOT*BITS_MAX-1:0]       i_Act,
    input  logic [N_DOT*BITS_MAX-1:0]       i_Weight,
    input  logic [BITS_SLICE_IDX-1:0]       i_PrecA,
    input  logic [BITS_SLICE_IDX-1:0]       i_PrecW,
    input  logic                            i_SignedA,
    input  logic                            i_SignedW,
    output logic                            o_Valid,
    input  logic                            i_Ready,
    output logic [N_DOT*BITS_PARALLEL-1:0]  o_Act,
    output logic [N_DOT*BITS_PARALLEL-1:0]  o_Weight,
    output logic                            o_SignI,
    output logic                            o_SignW,
    output logic [BITS_SHIFT-1:0]           o_Shift,
    output logic                            o_First,
    output logic                            o_Last
);

    localparam int unsigned BitsFull  = N_DOT * BITS_MAX;
    localparam int unsigned BitsSlice = N_DOT * BITS_PARALLEL;

    state_e                    state_q, state_d;
    logic                      ready_q, ready_d;
    logic [BitsFull-1:0]       act_q, act_d;
    logic [BitsFull-1:0]       wgt_q, wgt_d;
    // Last slice index (slice count minus one) is kept instead of the count itself.
    logic [BITS_SLICE_IDX-1:0] last_a_q, last_a_d;
    logic [BITS_SLICE_IDX-1:0] last_w_q, last_w_d;
    logic                      signed_a_q, signed_a_d;
    logic                      signed_w_q, signed_w_d;
    logic [BITS_SLICE_IDX-1:0] ia_q, ia_d;
    logic [BITS_SLICE_IDX-1:0] iw_q, iw_d;

    logic [BitsSlice-1:0]      act_slice;
    logic [BitsSlice-1:0]      wgt_slice;
    logic                      beat_valid;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            act_q      <= '0;
            wgt_q      <= '0;
            last_a_q   <= '0;
            last_w_q   <= '0;
            signed_a_q <= 1'b0;
            signed_w_q <= 1'b0;
            ia_q       <= '0;
            iw_q       <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            act_q      <= act_d;
            wgt_q      <= wgt_d;
            last_a_q   <= last_a_d;
            last_w_q   <= last_w_d;
            signed_a_q <= signed_a_d;
            signed_w_q <= signed_w_d;
            ia_q       <= ia_d;
            iw_q       <= iw_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        act_d      = act_q;
        wgt_d      = wgt_q;
        last_a_d   = last_a_q;
        last_w_d   = last_w_q;
        signed_a_d = signed_a_q;
        signed_w_d = signed_w_q;
        ia_d       = ia_q;
        iw_d       = iw_q;

        unique case (state_q)
            StIdle: begin
                // ready_q is low only in the first cycle after reset release.
                if (i_Valid && ready_q) begin
                    act_d      = i_Act;
                    wgt_d      = i_Weight;
                    last_a_d   = i_PrecA;
                    last_w_d   = i_PrecW;
                    signed_a_d = i_SignedA;
                    signed_w_d = i_SignedW;
                    ia_d       = '0;
                    iw_d       = '0;
                    state_d    = StRun;
                    ready_d    = 1'b0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            StRun: begin
                ready_d = 1'b0;
                if (i_Ready) begin
                    if (iw_q == last_w_q) begin
                        iw_d = '0;
                        if (ia_q == last_a_q) begin
                            ia_d    = '0;
                            state_d = StIdle;
                            ready_d = 1'b1;
                        end else begin
                            ia_d = ia_q + BITS_SLICE_IDX'(1);
                        end
                    end else begin
                        iw_d = iw_q + BITS_SLICE_IDX'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    for (genvar k = 0; k < N_DOT; k++) begin : g_elem
        sip_operand_slicer_slice_sel #(
            .BitsMax      (BITS_MAX),
            .BitsParallel (BITS_PARALLEL)
        ) u_act_sel (
            .operand_i (act_q[BITS_MAX*k +: BITS_MAX]),
            .idx_i     (ia_q),
            .slice_o   (act_slice[BITS_PARALLEL*k +: BITS_PARALLEL])
        );

        sip_operand_slicer_slice_sel #(
            .BitsMax      (BITS_MAX),
            .BitsParallel (BITS_PARALLEL)
        ) u_wgt_sel (
            .operand_i (wgt_q[BITS_MAX*k +: BITS_MAX]),
            .idx_i     (iw_q),
            .slice_o   (wgt_slice[BITS_PARALLEL*k +: BITS_PARALLEL])
        );
    end

    // All beat fields are forced to zero outside RUN so idle cycles carry no stale data.
    always_comb begin
        beat_valid = (state_q == StRun);
        o_Valid    = beat_valid;
        o_Ready    = ready_q;
        o_Act      = beat_valid ? act_slice : '0;
        o_Weight   = beat_valid ? wgt_slice : '0;
        o_SignI    = beat_valid && signed_a_q && (ia_q == last_a_q);
        o_SignW    = beat_valid && signed_w_q && (iw_q == last_w_q);
        o_Shift    = beat_valid ? shift_amt(ia_q, iw_q) : '0;
        o_First    = beat_valid && (ia_q == '0) && (iw_q == '0);
        o_Last     = beat_valid && (ia_q == last_a_q) && (iw_q == last_w_q);
    end

endmodule

// File: tb/tb_sip_operand_slicer.sv
// Self-checking bench: directed scenarios plus random traffic against a beat-queue model.
module tb_sip_operand_slicer;

    localparam int unsigned NDot = 32;
    localparam int unsigned BP   = 2;
    localparam int unsigned BM   = 8;

    typedef struct packed {
        logic [63:0] act;
        logic [63:0] wgt;
        logic        si;
        logic        sw;
        logic [3:0]  sh;
        logic        f;
        logic        l;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, out_ready, in_ready, out_valid;
    logic [NDot*BM-1:0]   act_in, wgt_in;
    logic [1:0]           prec_a, prec_w;
    logic                 sgn_a, sgn_w;
    logic [NDot*BP-1:0]   act_out, wgt_out;
    logic                 sign_i, sign_w, first, last;
    logic [3:0]           shift;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];
    bit    ready_en;

    always #5 clk = ~clk;

    sip_operand_slicer #(
        .N_DOT         (NDot),
        .BITS_PARALLEL (BP),
        .BITS_MAX      (BM)
    ) dut (
        .i_CLK     (clk),
        .i_RST     (rst),
        .i_Valid   (in_valid),
        .o_Ready   (out_ready),
        .i_Act     (act_in),
        .i_Weight  (wgt_in),
        .i_PrecA   (prec_a),
        .i_PrecW   (prec_w),
        .i_SignedA (sgn_a),
        .i_SignedW (sgn_w),
        .o_Valid   (out_valid),
        .i_Ready   (in_ready),
        .o_Act     (act_out),
        .o_Weight  (wgt_out),
        .o_SignI   (sign_i),
        .o_SignW   (sign_w),
        .o_Shift   (shift),
        .o_First   (first),
        .o_Last    (last)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rand_vec();
        for (int k = 0; k < int'(NDot * BM / 32); k++) begin
            act_in[32*k +: 32] = $urandom();
            wgt_in[32*k +: 32] = $urandom();
        end
        prec_a = 2'($urandom_range(0, 3));
        prec_w = 2'($urandom_range(0, 3));
        sgn_a  = 1'($urandom % 2);
        sgn_w  = 1'($urandom % 2);
    endtask

    // Expands the vector on the inputs into its full list of beats, ia outer / iw inner.
    task automatic push_vector();
        for (int a = 0; a <= int'(prec_a); a++) begin
            for (int w = 0; w <= int'(prec_w); w++) begin
                beat_t b;
                b = '0;
                for (int k = 0; k < int'(NDot); k++) begin
                    int ea, ew;
                    ea = int'(act_in[k*BM +: BM]);
                    ew = int'(wgt_in[k*BM +: BM]);
                    b.act[k*BP +: BP] = 2'((ea >> (2 * a)) % 4);
                    b.wgt[k*BP +: BP] = 2'((ew >> (2 * w)) % 4);
                end
                b.si = sgn_a && (a == int'(prec_a));
                b.sw = sgn_w && (w == int'(prec_w));
                b.sh = 4'(2 * (a + w));
                b.f  = (a == 0) && (w == 0);
                b.l  = (a == int'(prec_a)) && (w == int'(prec_w));
                exp_q.push_back(b);
            end
        end
    endtask

    // Called at a falling edge with inputs already set: checks outputs, advances the model
    // across the next rising edge, and returns at the following falling edge.
    task automatic run_cycle();
        beat_t b;
        bit    exp_rdy;
        exp_rdy = ready_en && (exp_q.size() == 0);
        b = (exp_q.size() != 0) ? exp_q[0] : '0;
        check_eq("o_Valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check_eq("o_Ready", 64'(out_ready), 64'(exp_rdy));
        check_eq("o_Act", 64'(act_out), b.act);
        check_eq("o_Weight", 64'(wgt_out), b.wgt);
        check_eq("o_SignI", 64'(sign_i), 64'(b.si));
        check_eq("o_SignW", 64'(sign_w), 64'(b.sw));
        check_eq("o_Shift", 64'(shift), 64'(b.sh));
        check_eq("o_First", 64'(first), 64'(b.f));
        check_eq("o_Last", 64'(last), 64'(b.l));
        if (exp_q.size() != 0 && in_ready) begin
            void'(exp_q.pop_front());
        end else if (exp_rdy && in_valid) begin
            push_vector();
        end
        ready_en = 1'b1;
        @(negedge clk);
    endtask

    logic [3:0]  plan_sh [16];
    logic [1:0]  plan_a  [4];
    logic [1:0]  plan_w  [4];
    logic [63:0] exp_pat;
    logic [1:0]  rdy_pat [8];

    initial begin
        plan_sh = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd2, 4'd4, 4'd6, 4'd8,
                    4'd4, 4'd6, 4'd8, 4'd10, 4'd6, 4'd8, 4'd10, 4'd12};
        plan_a  = '{2'b00, 2'b01, 2'b11, 2'b10};
        plan_w  = '{2'b10, 2'b11, 2'b01, 2'b01};
        rdy_pat = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b0;
        ready_en = 1'b0;
        rand_vec();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_ready", 64'(out_ready), 64'd0);
        check_eq("rst_act", 64'(act_out), 64'd0);
        check_eq("rst_shift", 64'(shift), 64'd0);
        check_eq("rst_last", 64'(last), 64'd0);
        rst = 1'b0;

        // 8b x 8b signed with the documented element-0 values.
        rand_vec();
        act_in[7:0] = 8'hB4;
        wgt_in[7:0] = 8'h5E;
        prec_a = 2'd3;
        prec_w = 2'd3;
        sgn_a = 1'b1;
        sgn_w = 1'b1;
        in_valid = 1'b1;
        in_ready = 1'b1;
        run_cycle();
        run_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_eq("t1_shift", 64'(shift), 64'(plan_sh[i]));
            check_eq("t1_act0", 64'(act_out[1:0]), 64'(plan_a[i/4]));
            check_eq("t1_wgt0", 64'(wgt_out[1:0]), 64'(plan_w[i%4]));
            check_eq("t1_signi", 64'(sign_i), 64'(i >= 12));
            run_cycle();
        end
        run_cycle();

        // 2b x 2b unsigned single beat; upper activation bits are garbage.
        rand_vec();
        exp_pat = '0;
        for (int k = 0; k < int'(NDot); k++) begin
            act_in[k*BM +: BM] = 8'hFC | 8'(k % 4);
            exp_pat[k*BP +: BP] = 2'(k % 4);
        end
        prec_a = 2'd0;
        prec_w = 2'd0;
        sgn_a = 1'b0;
        sgn_w = 1'b0;
        in_valid = 1'b1;
        run_cycle();
        in_valid = 1'b0;
        check_eq("t2_act", 64'(act_out), exp_pat);
        check_eq("t2_first_last", 64'({first, last}), 64'd3);
        run_cycle();
        run_cycle();

        // 4b x 4b with a three-cycle stall on beat 2.
        rand_vec();
        prec_a = 2'd1;
        prec_w = 2'd1;
        in_valid = 1'b1;
        run_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_ready = rdy_pat[i][0];
            run_cycle();
        end

        // Second vector held on the inputs throughout the first vector's run.
        in_ready = 1'b1;
        rand_vec();
        prec_a = 2'd1;
        prec_w = 2'd1;
        in_valid = 1'b1;
        run_cycle();
        rand_vec();
        prec_a = 2'd0;
        prec_w = 2'd1;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
        end

        // Asynchronous reset at beat 5 of an 8b x 8b run.
        rand_vec();
        prec_a = 2'd3;
        prec_w = 2'd3;
        in_valid = 1'b1;
        run_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
        end
        check_eq("t5_beat5_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_async_valid", 64'(out_valid), 64'd0);
        check_eq("t5_async_ready", 64'(out_ready), 64'd0);
        check_eq("t5_async_act", 64'(act_out), 64'd0);
        check_eq("t5_async_shift", 64'(shift), 64'd0);
        exp_q.delete();
        ready_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_cycle();
        rand_vec();
        for (int k = 0; k < int'(NDot); k++) begin
            act_in[k*BM +: BM] = {4'hF, 4'($urandom)};
        end
        prec_a = 2'd1;
        prec_w = 2'd3;
        in_valid = 1'b1;
        run_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run_cycle();
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            rand_vec();
            in_valid = 1'($urandom % 2);
            in_ready = ($urandom % 4) != 0;
            run_cycle();
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
